comparator_serial: RTL and testbench

Bit-serial, parametrised magnitude comparator with a start/done handshake and a run-time signed/unsigned mode. Operands are captured on `start`, then scanned MSB-first one bit per clock, with early termination at the first differing bit. Sits beside the combinational comparators where area matters more than latency, e.g. wide operands or shared datapaths.

---
 rtl/comparator_serial_if.sv | 24 ++
 rtl/comparator_serial.sv | 88 ++++++++
 tb/tb_comparator_serial.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/comparator_serial_if.sv
// rtl/comparator_serial_if.sv - request/result bundle for the bit-serial comparator
interface comparator_serial_if #(
  parameter int N = 4
);
  logic         start;
  logic         signed_mode;
  logic [N-1:0] x;
  logic [N-1:0] y;
  logic         busy;
  logic         done;
  logic         lt;
  logic         eq;
  logic         gt;

  modport master (
    output start, signed_mode, x, y,
    input  busy, done, lt, eq, gt
  );

  modport slave (
    input  start, signed_mode, x, y,
    output busy, done, lt, eq, gt
  );
endinterface

// File: rtl/comparator_serial.sv
// rtl/comparator_serial.sv - MSB-first bit-serial magnitude comparator, signed/unsigned
module comparator_serial #(
  parameter int N = 4
) (
  input logic                clk,
  input logic                rst,
  comparator_serial_if.slave bus
);
  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] IDX_TOP = IW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  logic [IW-1:0]  idx;
  logic [N-1:0]   x_r;
  logic [N-1:0]   y_r;
  logic           sm_r;

  // Capture on start, walk bits from the MSB down, stop at the first difference or at bit 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= IDX_TOP;
      x_r      <= '0;
      y_r      <= '0;
      sm_r     <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.lt   <= 1'b0;
      bus.eq   <= 1'b0;
      bus.gt   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            x_r      <= bus.x;
            y_r      <= bus.y;
            sm_r     <= bus.signed_mode;
            idx      <= IDX_TOP;
            bus.lt   <= 1'b0;
            bus.eq   <= 1'b0;
            bus.gt   <= 1'b0;
            bus.busy <= 1'b1;
            state    <= SCAN;
          end
        end
        SCAN: begin
          if (x_r[idx] != y_r[idx]) begin
            // In two's complement a set sign bit means the smaller value.
            if (sm_r && (idx == IDX_TOP)) begin
              bus.lt <= x_r[idx];
              bus.gt <= ~x_r[idx];
            end else begin
              bus.lt <= ~x_r[idx];
              bus.gt <= x_r[idx];
            end
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            state    <= DONE;
          end else if (idx == '0) begin
            bus.eq   <= 1'b1;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            state    <= DONE;
          end else begin
            idx <= idx - IW'(1);
          end
        end
        DONE: begin
          // Start is deliberately not sampled here; the next request waits for IDLE.
          bus.done <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_comparator_serial.sv
// tb/tb_comparator_serial.sv - self-checking bench for comparator_serial (N=4 and N=8)
module tb_comparator_serial;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  comparator_serial_if #(.N(4)) if4 ();
  comparator_serial_if #(.N(8)) if8 ();

  comparator_serial #(.N(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
  comparator_serial #(.N(8)) dut8 (.clk(clk), .rst(rst), .bus(if8.slave));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: compare the operands as plain integers in the selected number system.
  function automatic logic [2:0] exp_flags(input logic [7:0] a, input logic [7:0] b,
                                           input bit sm, input int n);
    int ua, ub, va, vb;
    ua = int'(a) & ((1 << n) - 1);
    ub = int'(b) & ((1 << n) - 1);
    va = (sm && ua >= (1 << (n - 1))) ? ua - (1 << n) : ua;
    vb = (sm && ub >= (1 << (n - 1))) ? ub - (1 << n) : ub;
    if (va < vb) return 3'b100;
    if (va == vb) return 3'b010;
    return 3'b001;
  endfunction

  function automatic int exp_lat(input logic [7:0] a, input logic [7:0] b, input int n);
    int lead;
    lead = 0;
    for (int i = n - 1; i >= 0; i--) begin
      if (a[i] != b[i]) break;
      lead++;
    end
    return (2 + lead > n + 1) ? n + 1 : 2 + lead;
  endfunction

  function automatic logic [2:0] flags(input bit wide);
    return wide ? {if8.lt, if8.eq, if8.gt} : {if4.lt, if4.eq, if4.gt};
  endfunction

  function automatic logic [4:0] outs4();
    return {if4.busy, if4.done, if4.lt, if4.eq, if4.gt};
  endfunction

  task automatic set_in(input bit wide, input logic [7:0] a, input logic [7:0] b,
                        input bit sm, input bit st);
    if (wide) begin
      if8.x = a; if8.y = b; if8.signed_mode = sm; if8.start = st;
    end else begin
      if4.x = a[3:0]; if4.y = b[3:0]; if4.signed_mode = sm; if4.start = st;
    end
  endtask

  // Called #1 after the accept edge; lat counts that edge as 1.
  task automatic wait_done(input bit wide, output int lat, output int busyc, output bit got);
    lat = 1; busyc = 0; got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (wide ? if8.done : if4.done) begin
        got = 1'b1;
        break;
      end
      if (wide ? if8.busy : if4.busy) busyc++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic op(input bit wide, input logic [7:0] a, input logic [7:0] b, input bit sm,
                    output int lat, output int busyc, output logic [2:0] f);
    bit got;
    @(posedge clk);
    @(negedge clk);
    set_in(wide, a, b, sm, 1'b1);
    @(posedge clk); #1;
    if4.start = 1'b0;
    if8.start = 1'b0;
    wait_done(wide, lat, busyc, got);
    chk("done_timeout", 32'(got), 32'd1);
    f = flags(wide);
  endtask

  initial begin
    int lat, bc, dcnt, first, second, k;
    logic [2:0] f;
    logic [7:0] a, b;
    bit sm, got;

    set_in(1'b0, 8'h0, 8'h0, 1'b0, 1'b0);
    set_in(1'b1, 8'h0, 8'h0, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs4", 32'(outs4()), 32'd0);
    chk("reset_outs8", 32'({if8.busy, if8.done, if8.lt, if8.eq, if8.gt}), 32'd0);
    rst = 1'b0;

    op(1'b0, 8'h0, 8'h0, 1'b1, lat, bc, f);
    chk("zero_eq_flags", 32'(f), 32'b010);
    chk("zero_eq_lat", lat, 5);
    chk("zero_eq_busy", bc, 4);

    op(1'b0, 8'hF, 8'h1, 1'b1, lat, bc, f);
    chk("f1_signed_flags", 32'(f), 32'b100);
    chk("f1_signed_lat", lat, 2);
    op(1'b0, 8'hF, 8'h1, 1'b0, lat, bc, f);
    chk("f1_unsigned_flags", 32'(f), 32'b001);
    chk("f1_unsigned_lat", lat, 2);

    op(1'b0, 8'h2, 8'h1, 1'b1, lat, bc, f);
    chk("21_gt_flags", 32'(f), 32'b001);
    chk("21_gt_lat", lat, 4);
    op(1'b0, 8'hC, 8'h2, 1'b1, lat, bc, f);
    chk("c2_lt_flags", 32'(f), 32'b100);
    chk("c2_lt_lat", lat, 2);

    // Live operand change and a stray start while scanning.
    @(posedge clk);
    @(negedge clk);
    set_in(1'b0, 8'hA, 8'hA, 1'b1, 1'b1);
    @(posedge clk); #1;
    if4.start = 1'b0;
    if4.x = 4'h0;
    @(negedge clk);
    if4.start = 1'b1;
    @(negedge clk);
    if4.start = 1'b0;
    got = 1'b0;
    for (int j = 0; j < 20; j++) begin
      @(posedge clk); #1;
      if (if4.done) begin got = 1'b1; break; end
    end
    chk("live_change_done", 32'(got), 32'd1);
    chk("live_change_eq", 32'(flags(1'b0)), 32'b010);
    dcnt = 0;
    for (int j = 0; j < 10; j++) begin
      @(posedge clk); #1;
      if (if4.done) dcnt++;
    end
    chk("stray_start_no_done", dcnt, 0);
    chk("flags_hold", 32'(flags(1'b0)), 32'b010);

    // Reset two cycles into a worst-case scan.
    @(negedge clk);
    set_in(1'b0, 8'h0, 8'h1, 1'b0, 1'b1);
    @(posedge clk); #1;
    if4.start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midscan_rst_outs", 32'(outs4()), 32'd0);
    rst = 1'b0;
    dcnt = 0;
    for (int j = 0; j < 8; j++) begin
      @(posedge clk); #1;
      if (if4.done) dcnt++;
    end
    chk("midscan_rst_no_done", dcnt, 0);
    op(1'b0, 8'h0, 8'h1, 1'b0, lat, bc, f);
    chk("after_rst_flags", 32'(f), 32'b100);
    chk("after_rst_lat", lat, 5);

    // Reset and start on the same edge.
    @(posedge clk);
    @(negedge clk);
    set_in(1'b0, 8'h5, 8'h3, 1'b0, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    if4.start = 1'b0;
    chk("rst_beats_start", 32'(outs4()), 32'd0);

    // Start held high: back-to-back with one idle cycle between operations.
    @(negedge clk);
    set_in(1'b0, 8'h8, 8'h0, 1'b0, 1'b1);
    first = 0; second = 0;
    for (k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (if4.done) begin
        if (first == 0) first = k;
        else if (second == 0) second = k;
      end
    end
    chk("b2b_first_done", first, 2);
    chk("b2b_gap", second - first, 3);
    chk("b2b_flags", 32'(flags(1'b0)), 32'b001);
    @(negedge clk);
    if4.start = 1'b0;
    repeat (4) @(posedge clk);

    // Randomized sweep on the 8-bit instance.
    for (int i = 0; i < 256; i++) begin
      a = 8'($urandom);
      case ($urandom_range(0, 3))
        0: b = a;
        1: b = a ^ (8'h1 << $urandom_range(0, 7));
        default: b = 8'($urandom);
      endcase
      sm = 1'($urandom_range(0, 1));
      op(1'b1, a, b, sm, lat, bc, f);
      chk("rand_flags", 32'(f), 32'(exp_flags(a, b, sm, 8)));
      chk("rand_onehot", $countones(f), 1);
      chk("rand_lat", lat, exp_lat(a, b, 8));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
